sobel_frame_ctrl: RTL and testbench

- Frame sequencer in front of sobel_mod.
- Accepts a start command with frame geometry, then pulls 24-bit BGR pixels from a source stream using a valid/ready handshake.
- Presents each pixel to sobel_mod as cam_red/green/blue plus a cam_done qualifier.
- Counts sobel_done results until the whole frame has drained, then reports completion, timeout or configuration errors.

---
 rtl/sobel_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer ahead of sobel_mod: pulls a raster of BGR pixels over valid/ready,
// feeds them to the filter with a one-cycle qualifier, and counts results until the frame drains.
module sobel_frame_ctrl #(
  parameter int unsigned MAX_W     = 1024,
  parameter int unsigned MAX_H     = 1024,
  parameter int unsigned DIM_W     = 11,
  parameter int unsigned DRAIN_TMO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DIM_W-1:0] cfg_width_i,
  input  logic [DIM_W-1:0] cfg_height_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic [7:0]       src_red_i,
  input  logic [7:0]       src_green_i,
  input  logic [7:0]       src_blue_i,
  output logic [7:0]       cam_red_o,
  output logic [7:0]       cam_green_o,
  output logic [7:0]       cam_blue_o,
  output logic             cam_done_o,
  input  logic             sobel_done_i,
  output logic [DIM_W-1:0] pix_x_o,
  output logic [DIM_W-1:0] pix_y_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             cfg_err_o,
  output logic             tmo_err_o
);

  localparam int unsigned CNT_W = 2 * DIM_W;
  localparam int unsigned TMO_W = $clog2(DRAIN_TMO + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   width_q, height_q, x_q, y_q;
  logic [CNT_W-1:0]   target_q, res_q, res_d;
  logic [TMO_W-1:0]   idle_q, idle_inc;
  logic               geom_ok, start_ok, accept, last_pix, counting, res_hit, tmo_hit;

  assign geom_ok = (cfg_width_i != '0) && (cfg_width_i[1:0] == 2'b00) &&
                   (cfg_width_i <= DIM_W'(MAX_W)) &&
                   (cfg_height_i != '0) && (cfg_height_i <= DIM_W'(MAX_H));

  assign start_ok     = (state_q == IDLE) && start_i && !abort_i;
  // Ready drops during an abort so the source never sees a handshake that gets discarded.
  assign src_ready_o  = (state_q == RUN) && !abort_i;
  assign accept       = src_valid_i && src_ready_o;
  assign last_pix     = (x_q == width_q - DIM_W'(1)) && (y_q == height_q - DIM_W'(1));
  assign counting     = (state_q == RUN) || (state_q == DRAIN);
  assign busy_o       = counting;
  assign frame_done_o = (state_q == DONE);

  // Result count saturates at the target, so early extra strobes in RUN cannot overshoot.
  assign res_d    = (counting && sobel_done_i && (res_q != target_q)) ? res_q + CNT_W'(1) : res_q;
  assign res_hit  = (res_d == target_q);
  assign idle_inc = idle_q + TMO_W'(1);
  assign tmo_hit  = !sobel_done_i && (idle_inc == TMO_W'(DRAIN_TMO));

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i && geom_ok) state_d = RUN;
        RUN:     if (accept && last_pix) state_d = DRAIN;
        DRAIN:   if (res_hit || tmo_hit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      target_q    <= '0;
      res_q       <= '0;
      idle_q      <= '0;
      cam_red_o   <= '0;
      cam_green_o <= '0;
      cam_blue_o  <= '0;
      cam_done_o  <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      cfg_err_o   <= 1'b0;
      tmo_err_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cam_done_o <= accept;

      if (accept) begin
        cam_red_o   <= src_red_i;
        cam_green_o <= src_green_i;
        cam_blue_o  <= src_blue_i;
        pix_x_o     <= x_q;
        pix_y_o     <= y_q;
        if (x_q == width_q - DIM_W'(1)) begin
          x_q <= '0;
          y_q <= y_q + DIM_W'(1);
        end else begin
          x_q <= x_q + DIM_W'(1);
        end
      end

      if (counting) res_q <= res_d;
      idle_q <= ((state_q == DRAIN) && !sobel_done_i) ? idle_inc : '0;

      if ((state_q == DRAIN) && !abort_i && tmo_hit && !res_hit) tmo_err_o <= 1'b1;

      if (start_ok) begin
        width_q   <= cfg_width_i;
        height_q  <= cfg_height_i;
        target_q  <= CNT_W'(cfg_width_i) * CNT_W'(cfg_height_i);
        x_q       <= '0;
        y_q       <= '0;
        res_q     <= '0;
        idle_q    <= '0;
        cfg_err_o <= !geom_ok;
        tmo_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: raster sequencing, geometry rejection, drain timeout,
// abort and mid-frame reset, with a 3-cycle echo model standing in for sobel_mod.
module tb_sobel_frame_ctrl;

  localparam int unsigned DIM_W = 11;
  localparam int unsigned TMO   = 64;

  logic             clk = 1'b0;
  logic             rst, start_i, abort_i, src_valid_i, sobel_done_i;
  logic [DIM_W-1:0] cfg_width_i, cfg_height_i;
  logic [7:0]       src_red_i, src_green_i, src_blue_i;
  logic             src_ready_o, cam_done_o, busy_o, frame_done_o, cfg_err_o, tmo_err_o;
  logic [7:0]       cam_red_o, cam_green_o, cam_blue_o;
  logic [DIM_W-1:0] pix_x_o, pix_y_o;

  sobel_frame_ctrl #(.MAX_W(1024), .MAX_H(1024), .DIM_W(DIM_W), .DRAIN_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_red_i(src_red_i), .src_green_i(src_green_i), .src_blue_i(src_blue_i),
    .cam_red_o(cam_red_o), .cam_green_o(cam_green_o), .cam_blue_o(cam_blue_o),
    .cam_done_o(cam_done_o), .sobel_done_i(sobel_done_i),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .cfg_err_o(cfg_err_o), .tmo_err_o(tmo_err_o)
  );

  always #5 clk = ~clk;

  // sobel_mod stand-in: echoes cam_done three cycles later, capped at sob_limit results.
  logic [2:0]  pipe = '0;
  int unsigned sob_issued = 0;
  int unsigned sob_limit  = '1;
  assign sobel_done_i = pipe[2] && (sob_issued < sob_limit);
  always @(posedge clk) begin
    pipe <= {pipe[1:0], cam_done_o};
    if (sobel_done_i) sob_issued <= sob_issued + 1;
  end

  typedef struct packed {
    logic [23:0]      rgb;
    logic [DIM_W-1:0] x;
    logic [DIM_W-1:0] y;
    int               cyc;
  } cam_ev_t;

  cam_ev_t cam_q[$];
  int cyc = 0, sob_cnt = 0, sob_cyc = 0, fd_cnt = 0, fd_cyc = 0, tmo_cyc = 0;
  int rdy_cnt = 0, bad_cam = 0;
  logic prev_acc = 1'b0, tmo_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (cam_done_o) begin
      cam_q.push_back({cam_red_o, cam_green_o, cam_blue_o, pix_x_o, pix_y_o, cyc});
      if (!prev_acc) bad_cam <= bad_cam + 1;
    end
    prev_acc <= src_valid_i && src_ready_o;
    if (src_ready_o) rdy_cnt <= rdy_cnt + 1;
    if (sobel_done_i) begin
      sob_cnt <= sob_cnt + 1;
      sob_cyc <= cyc;
    end
    if (frame_done_o) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
    if (tmo_err_o && !tmo_prev) tmo_cyc <= cyc;
    tmo_prev <= tmo_err_o;
  end

  int errors = 0;
  int checks = 0;
  int src_idx = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 7 + 3);
    g = 8'(8'h40 + i);
    b = 8'(8'hC0 - i);
    return {r, g, b};
  endfunction

  function automatic logic [63:0] out_vec();
    return 64'({src_ready_o, cam_red_o, cam_green_o, cam_blue_o, cam_done_o, pix_x_o, pix_y_o,
                busy_o, frame_done_o, cfg_err_o, tmo_err_o});
  endfunction

  task automatic drive_pix();
    logic [23:0] p;
    p = pix(src_idx);
    {src_red_i, src_green_i, src_blue_i} = p;
  endtask

  task automatic step(input bit toggle);
    logic acc;
    @(negedge clk);
    acc = src_valid_i && src_ready_o;
    @(posedge clk);
    #1;
    if (acc) src_idx++;
    if (toggle) src_valid_i = !src_valid_i;
    drive_pix();
  endtask

  task automatic start_frame(input int w, input int h);
    @(posedge clk);
    #1;
    start_i      = 1'b1;
    cfg_width_i  = DIM_W'(w);
    cfg_height_i = DIM_W'(h);
    src_idx      = 0;
    src_valid_i  = 1'b1;
    drive_pix();
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int fd0, input bit toggle);
    int n;
    n = 0;
    while (fd_cnt == fd0 && n < 400) begin
      step(toggle);
      n++;
    end
    check_eq({tag, "_frame_done_count"}, 64'(fd_cnt - fd0), 64'd1);
  endtask

  task automatic check_pixels(input string tag, input int base, input int n, input int w);
    logic [DIM_W-1:0] ex, ey;
    check_eq({tag, "_cam_done_count"}, 64'(cam_q.size() - base), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < cam_q.size()) begin
        ex = DIM_W'(k % w);
        ey = DIM_W'(k / w);
        check_eq($sformatf("%s_pix%0d", tag, k),
                 64'({cam_q[base+k].rgb, cam_q[base+k].x, cam_q[base+k].y}),
                 64'({pix(k), ex, ey}));
      end
    end
  endtask

  initial begin
    int b, fd0, sob0, rdy0, bad0, n;
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; src_valid_i = 1'b0;
    cfg_width_i = '0; cfg_height_i = '0;
    drive_pix();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    repeat (2) step(1'b0);

    // 4x2 frame, source always valid
    b = cam_q.size(); fd0 = fd_cnt; sob0 = sob_cnt;
    start_frame(4, 2);
    check_eq("t1_busy_after_start", 64'(busy_o), 64'd1);
    wait_frame("t1", fd0, 1'b0);
    check_pixels("t1", b, 8, 4);
    if (cam_q.size() >= b + 8)
      check_eq("t1_cam_consecutive", 64'(cam_q[b+7].cyc - cam_q[b].cyc), 64'd7);
    check_eq("t1_sobel_count", 64'(sob_cnt - sob0), 64'd8);
    check_eq("t1_done_after_last_result", 64'(fd_cyc - sob_cyc), 64'd1);
    step(1'b0);
    check_eq("t1_busy_after", 64'(busy_o), 64'd0);
    check_eq("t1_flags", 64'({cfg_err_o, tmo_err_o}), 64'd0);

    // illegal width 6, then a legal 8x1 frame
    b = cam_q.size(); rdy0 = rdy_cnt;
    start_frame(6, 2);
    repeat (20) step(1'b0);
    check_eq("t2_cfg_err", 64'(cfg_err_o), 64'd1);
    check_eq("t2_ready_cycles", 64'(rdy_cnt - rdy0), 64'd0);
    check_eq("t2_no_cam_done", 64'(cam_q.size() - b), 64'd0);
    check_eq("t2_busy", 64'(busy_o), 64'd0);
    b = cam_q.size(); fd0 = fd_cnt;
    start_frame(8, 1);
    check_eq("t2_cfg_err_cleared", 64'(cfg_err_o), 64'd0);
    wait_frame("t2", fd0, 1'b0);
    check_pixels("t2", b, 8, 8);
    repeat (5) step(1'b0);

    // 4x1 frame with valid toggling every cycle
    b = cam_q.size(); fd0 = fd_cnt; bad0 = bad_cam;
    start_frame(4, 1);
    wait_frame("t3", fd0, 1'b1);
    check_pixels("t3", b, 4, 4);
    check_eq("t3_cam_without_accept", 64'(bad_cam - bad0), 64'd0);
    src_valid_i = 1'b1;
    repeat (5) step(1'b0);

    // only three results come back: drain timeout
    sob_limit = sob_issued + 3;
    fd0 = fd_cnt; sob0 = sob_cnt;
    start_frame(4, 1);
    wait_frame("t4", fd0, 1'b0);
    check_eq("t4_sobel_count", 64'(sob_cnt - sob0), 64'd3);
    check_eq("t4_tmo_err", 64'(tmo_err_o), 64'd1);
    // result strobe is taken on the edge after its cycle; the flag follows TMO idle cycles later
    check_eq("t4_tmo_delay", 64'(tmo_cyc - (sob_cyc + 1)), 64'(TMO));
    check_eq("t4_done_with_tmo", 64'(fd_cyc), 64'(tmo_cyc));
    step(1'b0);
    check_eq("t4_idle_after", 64'(busy_o), 64'd0);
    sob_limit = '1;
    repeat (5) step(1'b0);

    // abort after the 5th pixel of a 4x4 frame, start pulsed alongside
    b = cam_q.size(); fd0 = fd_cnt;
    start_frame(4, 4);
    n = 0;
    while (src_idx < 5 && n < 50) begin
      step(1'b0);
      n++;
    end
    check_eq("t5_reached_5_accepts", 64'(src_idx), 64'd5);
    src_valid_i = 1'b0; abort_i = 1'b1; start_i = 1'b1;
    cfg_width_i = DIM_W'(4); cfg_height_i = DIM_W'(1);
    @(posedge clk);
    #1;
    abort_i = 1'b0; start_i = 1'b0;
    check_eq("t5_after_abort", 64'({busy_o, src_ready_o, cam_done_o, frame_done_o}), 64'd0);
    repeat (10) step(1'b0);
    check_eq("t5_start_ignored", 64'(busy_o), 64'd0);
    check_eq("t5_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    check_eq("t5_cam_count", 64'(cam_q.size() - b), 64'd5);

    // reset while draining, then a normal 4x1 frame
    sob_limit = sob_issued + 2;
    start_frame(4, 1);
    n = 0;
    while (src_idx < 4 && n < 50) begin
      step(1'b0);
      n++;
    end
    repeat (3) step(1'b0);
    check_eq("t6_in_drain", 64'({busy_o, src_ready_o}), 64'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("t6_reset_outputs", out_vec(), 64'd0);
    repeat (5) step(1'b0);
    sob_limit = '1;
    b = cam_q.size(); fd0 = fd_cnt;
    start_frame(4, 1);
    wait_frame("t6", fd0, 1'b0);
    check_pixels("t6", b, 4, 4);
    check_eq("t6_flags", 64'({cfg_err_o, tmo_err_o}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
